svc_uart_rx: RTL
================

// Module: svc_uart_rx
//
// PURPOSE
// - 8N1 UART receiver. It is the receive-direction counterpart of the SoC uart_tx path.
// - Feeds host-to-SoC bytes (e.g. a console or loader) into the CPU peripheral bus over a valid/ready byte stream.
// - The asynchronous input is synchronised, mid-bit sampled with 3-sample majority, framed, and held in a 1-entry output buffer.
//
// PARAMETERS
// - CLOCK_FREQ  25_000_000  clk frequency in Hz
// - BAUD_RATE   115_200     line rate in bits/s
// - CPB         CLOCK_FREQ/BAUD_RATE (localparam, truncating)  clks per bit
// - MID         CPB/2 (localparam)  sample centre within a bit
//
// PORTS
// - clk            in   1  clock
// - rst            in   1  synchronous, active-high reset
// - urx_pin        in   1  asynchronous serial line, idle high
// - urx_valid      out  1  urx_data holds an unconsumed byte
// - urx_data       out  8  received byte, LSB-first on the wire
// - urx_ready      in   1  consumer accepts byte when urx_valid&&urx_ready
// - urx_frame_err  out  1  1-cycle pulse: stop bit sampled 0
// - urx_overrun    out  1  1-cycle pulse: frame completed while buffer full
//
// BEHAVIOUR
// - Reset values: urx_valid=0, urx_data=0, urx_frame_err=0, urx_overrun=0, state=IDLE.
// - The synchroniser flops reset to 1.
// - Synchronisation: urx_pin passes through 2 flops to give rx_s.
// - All timing below is relative to rx_s.
// - Bit counter cnt runs 0..CPB-1 within each bit.
// - Majority samples are taken at cnt=MID-1, MID and MID+1.
// - The bit value is decided at cnt=MID+1 as majority(3).
// - States:
//   - IDLE: on rx_s==0, go to START with cnt=0.
//   - START: at the decision point, majority=1 is a glitch; go to IDLE with no output.
//     Otherwise continue; at cnt=CPB-1 go to DATA with bit=0.
//   - DATA: shift the decided bit into shreg[7] (shift right).
//     At cnt=CPB-1, bit++. After bit 7, go to STOP.
//   - STOP: at the decision point, evaluate majority.
//     - majority=1 and !urx_valid: urx_data<=shreg, urx_valid<=1 next cycle, go to IDLE.
//       Do not wait for the end of the stop bit; this allows resync on back-to-back frames.
//     - majority=1 and urx_valid: drop the byte, pulse urx_overrun, go to IDLE. urx_data is unchanged.
//     - majority=0: drop the byte, pulse urx_frame_err, go to BREAK.
//   - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering frames.
// - Handshake:
//   - urx_valid stays high, and urx_data stays stable, until a cycle with urx_ready=1.
//   - urx_valid clears the cycle after acceptance.
// - Simultaneous accept and new byte in the same cycle: this is not an overrun.
//   The new byte loads and urx_valid stays 1.
// - Latency: urx_valid rises 1 cycle after the stop decision point.
//   That is about 9*CPB+MID+2 clks after the rx_s falling edge.
// - rst mid-frame: immediate return to IDLE. The partial byte and any buffered byte are discarded.
// - Data bits are sampled regardless of value; there is no parity.
// - The error pulses last exactly 1 cycle and are never simultaneous.
// - Elaboration assertion: CPB>=8.
//
// STRUCTURE
// - svc_uart_pkg holds:
//   - typedef enum logic [2:0] {IDLE,START,DATA,STOP,BREAK} uart_rx_state_t
//   - function clks_per_bit(freq,baud), shared with the tx side
//   - localparam UART_DATA_BITS=8
// - Sub-module: svc_sync_bit, a 2-flop synchroniser with a reset value parameter (1 here).
// - Everything else (counter, majority, FSM, output buffer) stays inline.
//
// TESTING
// - The bench uses CLOCK_FREQ=16, BAUD_RATE=1, so CPB=16 and MID=8.
// - Cases:
//   1. Send 0x55 8N1 with urx_ready=1. Expect a single urx_valid cycle with urx_data=0x55 and no error pulses.
//   2. Drive a 4-clk low glitch on an idle line, then send frame 0xA3.
//      Expect no output for the glitch, then exactly one byte 0xA3.
//   3. Send 0x00 with the stop bit low, then hold the line low 40 clks, release it, and send 0x81.
//      Expect 1 urx_frame_err pulse, no spurious frames, then 0x81.
//   4. Hold urx_ready=0 and send 0x12 then 0x34.
//      Expect urx_data=0x12 held and urx_overrun pulsed once.
//      When urx_ready is then raised, 0x12 is accepted and 0x34 never appears.
//   5. Send 0xC3 with urx_ready=1 and a 1-clk inverted spike at cnt=MID on every data bit.
//      Expect 0xC3, since the majority vote rejects the spike.
//   6. Assert rst during data bit 4 of 0xF0, release it, then send 0x5A and 0xA5 back-to-back with a 1-bit stop.
//      Expect urx_valid=0 during reset, no 0xF0, then 0x5A followed by 0xA5.

Source files
------------

// File: rtl/svc_uart_pkg.sv
// rtl/svc_uart_pkg.sv - shared UART types, constants and helpers
package svc_uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

   localparam int UART_DATA_BITS = 8;

   // Truncating clocks-per-bit, shared with the transmit side
   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/svc_uart_rx_if.sv
// rtl/svc_uart_rx_if.sv - received-byte valid/ready stream
interface svc_uart_rx_if;
   import svc_uart_pkg::*;

   logic                      urx_valid;
   logic [UART_DATA_BITS-1:0] urx_data;
   logic                      urx_ready;

   modport master (output urx_valid, output urx_data, input urx_ready);
   modport slave  (input urx_valid, input urx_data, output urx_ready);

endinterface

// File: rtl/svc_sync_bit.sv
// rtl/svc_sync_bit.sv - 2-flop synchroniser with a configurable reset value
module svc_sync_bit #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; resetting to the idle level avoids a false start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/svc_uart_rx.sv
// rtl/svc_uart_rx.sv - 8N1 UART receiver with majority sampling and 1-entry output buffer
module svc_uart_rx
   import svc_uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 25_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               urx_pin,
   svc_uart_rx_if.master      rx,
   output logic               urx_frame_err,
   output logic               urx_overrun
);

   localparam int CPB = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int MID = CPB / 2;
   localparam int CW  = $clog2(CPB);
   localparam int BW  = $clog2(UART_DATA_BITS);

   localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
   localparam logic [CW-1:0] C_S1   = CW'(MID);
   localparam logic [CW-1:0] C_DEC  = CW'(MID + 1);
   localparam logic [BW-1:0] B_LAST = BW'(UART_DATA_BITS - 1);

   if (CPB < 8) begin : g_bad_cpb
      $error("svc_uart_rx: clocks per bit must be at least 8");
   end

   logic                      rx_s;
   logic [CW-1:0]             cnt;
   logic [BW-1:0]             bit_idx;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      s0;
   logic                      s1;
   logic                      maj;
   logic                      buf_full;
   uart_rx_state_t            state;

   svc_sync_bit #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (urx_pin),
      .q   (rx_s)
   );

   // Third sample is the live rx_s at the decision point
   assign maj      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
   // A byte accepted this very cycle frees the buffer for a new one
   assign buf_full = rx.urx_valid && !rx.urx_ready;

   // Receive FSM: bit timing, majority sampling, framing and output buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         s0            <= 1'b1;
         s1            <= 1'b1;
         rx.urx_valid  <= 1'b0;
         rx.urx_data   <= '0;
         urx_frame_err <= 1'b0;
         urx_overrun   <= 1'b0;
      end else begin
         urx_frame_err <= 1'b0;
         urx_overrun   <= 1'b0;
         if (rx.urx_valid && rx.urx_ready) begin
            rx.urx_valid <= 1'b0;
         end
         if (state != IDLE && state != BREAK) begin
            cnt <= (cnt == C_LAST) ? '0 : cnt + 1'b1;
            if (cnt == C_S0) s0 <= rx_s;
            if (cnt == C_S1) s1 <= rx_s;
         end
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == C_DEC && maj) begin
                  state <= IDLE;
               end else if (cnt == C_LAST) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (cnt == C_DEC) begin
                  shreg <= {maj, shreg[UART_DATA_BITS-1:1]};
               end
               if (cnt == C_LAST) begin
                  if (bit_idx == B_LAST) state <= STOP;
                  else bit_idx <= bit_idx + 1'b1;
               end
            end
            STOP: begin
               // Leave at the stop decision so back-to-back frames can resync
               if (cnt == C_DEC) begin
                  if (!maj) begin
                     urx_frame_err <= 1'b1;
                     state         <= BREAK;
                  end else if (buf_full) begin
                     urx_overrun <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     rx.urx_data  <= shreg;
                     rx.urx_valid <= 1'b1;
                     state        <= IDLE;
                  end
               end
            end
            BREAK: begin
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
